// File: rtl/decoder_3to8_strobe_pkg.sv
// Shared types and constants for the 3-to-8 strobe decoder.
// Includes the HOLD/GAP legality helper used by the checker.
package decoder_3to8_strobe_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // HOLD must be 1..255 and GAP 0..255 so the 8-bit counter never wraps.
  function automatic bit hold_gap_ok(input int hold, input int gap);
    return (hold >= 32'sd1) && (hold <= 32'sd255) && (gap >= 32'sd0) && (gap <= 32'sd255);
  endfunction

endpackage

// File: rtl/decoder_3to8_strobe_chk.sv
// Runtime checks for the strobe decoder: legal parameters, one-hot output,
// and done only ever asserted while busy.
module decoder_3to8_strobe_chk
  import decoder_3to8_strobe_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic [7:0] i_out,
  input logic       i_busy,
  input logic       i_done
);

  a_params_legal: assert property (@(posedge i_clk) hold_gap_ok(HOLD, GAP));

  a_out_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(i_out));

  a_done_when_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_done |-> i_busy);

endmodule

// File: rtl/decoder_3to8_strobe_onehot.sv
// Combinational 3-bit index to one-hot 8-bit line decoder.
module onehot_decoder_3to8 (
  input  logic [2:0] i_code,
  output logic [7:0] o_onehot
);

  assign o_onehot = 8'b0000_0001 << i_code;

endmodule

// File: rtl/decoder_3to8_strobe.sv
// Accepts a 3-bit index over valid/ready and drives the matching line
// high for HOLD cycles, then GAP cycles of zero before accepting again.
module decoder_3to8_strobe
  import decoder_3to8_strobe_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 1);
  localparam logic             GAP_EN    = (GAP > 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_out;
  logic [7:0]       w_out_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [7:0]       w_onehot;

  onehot_decoder_3to8 u_onehot (
    .i_code   (code),
    .o_onehot (w_onehot)
  );

  // Next-state, counter, output and done decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
          w_out_nxt   = w_onehot;
        end else begin
          w_out_nxt   = 8'h00;
        end
      end
      ST_HOLD: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_out_nxt = 8'h00;
          if (GAP_EN) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end
        end
      end
      ST_GAP: begin
        w_out_nxt = 8'h00;
        if (r_cnt != CNT_ZERO) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_out_nxt   = 8'h00;
      end
    endcase
    // done marks the cycle that will be the final hold cycle.
    w_done_nxt = (w_state_nxt == ST_HOLD) && (w_cnt_nxt == CNT_ZERO);
  end

  // State, counter and output registers; reset aborts any strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_out   <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign out      = r_out;
  assign done     = r_done;

  decoder_3to8_strobe_chk #(.HOLD(HOLD), .GAP(GAP)) u_chk (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_out   (r_out),
    .i_busy  (busy),
    .i_done  (r_done)
  );

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Directed self-checking bench: one instance with HOLD=4/GAP=1, one with HOLD=1/GAP=0.
module tb_decoder_3to8_strobe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid = 1'b0;
  logic [2:0] a_code = 3'd0;
  logic       a_ready, a_busy, a_done;
  logic [7:0] a_out;

  logic       b_valid = 1'b0;
  logic [2:0] b_code = 3'd0;
  logic       b_ready, b_busy, b_done;
  logic [7:0] b_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_3to8_strobe #(.HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .code(a_code), .out(a_out), .busy(a_busy), .done(a_done)
  );

  decoder_3to8_strobe #(.HOLD(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .code(b_code), .out(b_out), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_ab [10];
  logic [7:0] exp_b  [5];
  logic       exp_bd [5];

  initial begin
    exp_ab = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80};
    exp_b  = '{8'h08, 8'h00, 8'h04, 8'h00, 8'h02};
    exp_bd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_out",   a_out,   8'h00);
    check("rst_ready", a_ready, 1'b1);
    check("rst_busy",  a_busy,  1'b0);
    check("rst_done",  a_done,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_out",   a_out,   8'h00);
    check("idle_ready", a_ready, 1'b1);
    check("idle_b_out", b_out,   8'h00);

    // Single accept of code 5.
    a_valid = 1'b1;
    a_code  = 3'd5;
    tick();
    a_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("single_out",   a_out,   8'h20);
      check("single_done",  a_done,  (i == 4) ? 1'b1 : 1'b0);
      check("single_busy",  a_busy,  1'b1);
      check("single_ready", a_ready, 1'b0);
      if (i < 4) tick();
    end
    tick();
    check("gap_out",   a_out,   8'h00);
    check("gap_busy",  a_busy,  1'b1);
    check("gap_ready", a_ready, 1'b0);
    check("gap_done",  a_done,  1'b0);
    tick();
    check("back_idle_ready", a_ready, 1'b1);
    check("back_idle_busy",  a_busy,  1'b0);

    // Back-to-back with valid held: code 0 then 7, spaced six cycles.
    a_valid = 1'b1;
    a_code  = 3'd0;
    tick();
    a_code  = 3'd7;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      check("b2b_out",   a_out,   exp_ab[j]);
      check("b2b_ready", a_ready, (j == 5) ? 1'b1 : 1'b0);
      if (j == 6) a_valid = 1'b0;
    end
    repeat (2) tick();
    check("b2b_end_ready", a_ready, 1'b1);

    // HOLD=1, GAP=0 instance: codes 3, 2, 1 with valid held.
    b_valid = 1'b1;
    b_code  = 3'd3;
    tick();
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      check("h1_out",  b_out,  exp_b[j]);
      check("h1_done", b_done, exp_bd[j]);
      if (j == 0) b_code = 3'd2;
      if (j == 2) b_code = 3'd1;
      if (j == 4) b_valid = 1'b0;
    end
    tick();
    check("h1_end_out",   b_out,   8'h00);
    check("h1_end_ready", b_ready, 1'b1);

    // Exhaustive codes on the HOLD=4 instance.
    for (int c = 0; c < 8; c++) begin
      logic [7:0] one;
      one = 8'h01;
      a_valid = 1'b1;
      a_code  = 3'(c);
      tick();
      a_valid = 1'b0;
      check("exh_out", a_out, one << c);
      repeat (5) tick();
      check("exh_ready", a_ready, 1'b1);
    end

    // Async reset during the second hold cycle of code 6.
    a_valid = 1'b1;
    a_code  = 3'd6;
    tick();
    a_valid = 1'b0;
    check("ar_first_out", a_out, 8'h40);
    tick();
    check("ar_second_out", a_out, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_cleared", a_out,   8'h00);
    check("ar_busy",        a_busy,  1'b0);
    check("ar_ready",       a_ready, 1'b1);
    check("ar_done",        a_done,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_post_ready", a_ready, 1'b1);
    check("ar_post_done",  a_done,  1'b0);
    check("ar_post_out",   a_out,   8'h00);
    tick();
    check("ar_post_done2", a_done,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Every sampled cycle the outputs must be one-hot or zero.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_onehot0", $onehot0(a_out), 1'b1);
      check("b_onehot0", $onehot0(b_out), 1'b1);
    end
  end

endmodule
